// File: rtl/g15_tape_pkg.sv
// Shared types and constants for the G-15 photoelectric tape reader model.
//   STOP_CODE   : frame value that marks a block boundary on the tape
//   frame_t     : one 5-bit tape frame
//   ptr_state_t : reader sequencing states
//   max3        : elaboration helper used to size the shared pacing timer
package g15_tape_pkg;

   typedef logic [4:0] frame_t;

   localparam frame_t STOP_CODE = 5'b10000;

   typedef enum logic [2:0] {
      IDLE,
      START,
      FWD_READ,
      FWD_WAIT,
      FWD_EOT,
      REV_STEP,
      REV_WAIT
   } ptr_state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/photo_tape_reader_if.sv
// Command, host-load and frame-output bundle of the photo tape reader.
//   master : I/O control / host side (drives commands and tape image)
//   slave  : reader side (drives frames and status)
//   PHOTO_TAPE_FWD  level, run forward        TAPE_REV_CMD  pulse, reverse search
//   HOST_WE/ADDR/DATA  frame write            HOST_LEN_WE/HOST_LEN  tape length load
//   PT_DATA/PT_STROBE/PT_STOP  frame output   PHOTO_TAPE_REV, PT_EOT, BUSY  status
interface photo_tape_reader_if #(
   parameter int DEPTH = 4096
);
   localparam int AW = $clog2(DEPTH);

   logic                  PHOTO_TAPE_FWD;
   logic                  TAPE_REV_CMD;
   logic                  HOST_WE;
   logic [AW-1:0]         HOST_ADDR;
   g15_tape_pkg::frame_t  HOST_DATA;
   logic                  HOST_LEN_WE;
   logic [AW:0]           HOST_LEN;
   g15_tape_pkg::frame_t  PT_DATA;
   logic                  PT_STROBE;
   logic                  PT_STOP;
   logic                  PHOTO_TAPE_REV;
   logic                  PT_EOT;
   logic                  BUSY;

   modport master (
      output PHOTO_TAPE_FWD, TAPE_REV_CMD, HOST_WE, HOST_ADDR, HOST_DATA,
             HOST_LEN_WE, HOST_LEN,
      input  PT_DATA, PT_STROBE, PT_STOP, PHOTO_TAPE_REV, PT_EOT, BUSY
   );

   modport slave (
      input  PHOTO_TAPE_FWD, TAPE_REV_CMD, HOST_WE, HOST_ADDR, HOST_DATA,
             HOST_LEN_WE, HOST_LEN,
      output PT_DATA, PT_STROBE, PT_STOP, PHOTO_TAPE_REV, PT_EOT, BUSY
   );

endinterface

// File: rtl/tape_ram.sv
// Tape image storage: DEPTH x 5-bit frames.
//   clk          : clock
//   we/waddr/wdata : host write port
//   re/raddr/rdata : synchronous read port, one-cycle latency; rdata holds
//                    its value while re is low
// Contents are never cleared, so a reset leaves the loaded tape intact.
module tape_ram
   import g15_tape_pkg::*;
#(
   parameter int DEPTH = 4096,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  frame_t        wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output frame_t        rdata
);

   frame_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/photo_tape_reader.sv
// Peripheral-side model of the G-15 photoelectric tape reader.
//   CLOCK : system clock
//   rst   : synchronous active-high reset
//   bus   : slave side of photo_tape_reader_if (commands, host load, frames, status)
// Forward motion delivers one frame every CHAR_CYCLES after a START_CYCLES
// spin-up; reverse motion steps back one frame per REV_CYCLES until it has
// just passed a stop code or reached the tape start.
module photo_tape_reader
   import g15_tape_pkg::*;
#(
   parameter int DEPTH        = 4096,
   parameter int CHAR_CYCLES  = 1000,
   parameter int REV_CYCLES   = 250,
   parameter int START_CYCLES = 2000
) (
   input  logic              CLOCK,
   input  logic              rst,
   photo_tape_reader_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int TW = $clog2(max3(CHAR_CYCLES, REV_CYCLES, START_CYCLES)) + 1;

   ptr_state_t    state_reg, state_next;
   logic [PW-1:0] pos_reg, pos_next;
   logic [PW-1:0] len_reg, len_next;
   logic [TW-1:0] timer_reg, timer_next;
   frame_t        data_reg, data_next;

   logic          rd_en;
   logic [AW-1:0] rd_addr;
   frame_t        rdata;
   logic          wr_en;
   logic [PW-1:0] pos_m1;
   logic [PW-1:0] pos_m2;
   logic [PW-1:0] len_clamped;

   logic          strobe;
   logic          stop;
   logic          rev;
   logic          busy;
   logic          eot;
   frame_t        pt_data;

   assign wr_en       = bus.HOST_WE && (state_reg == IDLE);
   assign pos_m1      = pos_reg - PW'(1);
   assign pos_m2      = pos_reg - PW'(2);
   assign len_clamped = (bus.HOST_LEN > PW'(DEPTH)) ? PW'(DEPTH) : bus.HOST_LEN;

   tape_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_tape_ram (
      .clk   (CLOCK),
      .we    (wr_en),
      .waddr (bus.HOST_ADDR),
      .wdata (bus.HOST_DATA),
      .re    (rd_en),
      .raddr (rd_addr),
      .rdata (rdata)
   );

   // State register
   always_ff @(posedge CLOCK) begin
      if (rst) begin
         state_reg <= IDLE;
         pos_reg   <= '0;
         len_reg   <= '0;
         timer_reg <= '0;
         data_reg  <= '0;
      end else begin
         state_reg <= state_next;
         pos_reg   <= pos_next;
         len_reg   <= len_next;
         timer_reg <= timer_next;
         data_reg  <= data_next;
      end
   end

   // Next-state and datapath
   always_comb begin
      state_next = state_reg;
      pos_next   = pos_reg;
      len_next   = len_reg;
      timer_next = (timer_reg != '0) ? timer_reg - TW'(1) : timer_reg;
      data_next  = data_reg;
      rd_en      = 1'b0;
      rd_addr    = pos_reg[AW-1:0];

      case (state_reg)
         IDLE: begin
            timer_next = '0;
            // A length load rewinds the tape; motion starts on a later cycle
            if (bus.HOST_LEN_WE) begin
               len_next = len_clamped;
               pos_next = '0;
            end else if (bus.TAPE_REV_CMD && (pos_reg != '0)) begin
               state_next = REV_STEP;
            end else if (bus.PHOTO_TAPE_FWD && (pos_reg < len_reg)) begin
               state_next = START;
               timer_next = TW'(START_CYCLES - 1);
            end
         end

         START: begin
            if (!bus.PHOTO_TAPE_FWD) begin
               state_next = IDLE;
            end else if (timer_reg == '0) begin
               rd_en      = 1'b1;
               state_next = FWD_READ;
            end
         end

         FWD_READ: begin
            data_next  = rdata;
            pos_next   = pos_reg + PW'(1);
            // READ itself is one cycle of the CHAR_CYCLES spacing
            timer_next = TW'(CHAR_CYCLES - 2);
            state_next = FWD_WAIT;
         end

         FWD_WAIT: begin
            if (!bus.PHOTO_TAPE_FWD) begin
               state_next = IDLE;
            end else if (timer_reg == '0) begin
               if (pos_reg < len_reg) begin
                  rd_en      = 1'b1;
                  state_next = FWD_READ;
               end else begin
                  state_next = FWD_EOT;
               end
            end
         end

         FWD_EOT: begin
            if (!bus.PHOTO_TAPE_FWD) state_next = IDLE;
         end

         REV_STEP: begin
            // Look at the frame behind the new position; the frame directly
            // behind the starting position is thereby always stepped over.
            pos_next   = pos_m1;
            rd_addr    = pos_m2[AW-1:0];
            rd_en      = (pos_reg >= PW'(2));
            timer_next = TW'(REV_CYCLES - 1);
            state_next = REV_WAIT;
         end

         REV_WAIT: begin
            if (timer_reg == '0) begin
               if ((pos_reg == '0) || (rdata == STOP_CODE)) state_next = IDLE;
               else                                         state_next = REV_STEP;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      strobe  = (state_reg == FWD_READ);
      stop    = strobe && (rdata == STOP_CODE);
      pt_data = strobe ? rdata : data_reg;
      rev     = (state_reg == REV_STEP) || (state_reg == REV_WAIT);
      busy    = (state_reg != IDLE);
      eot     = (pos_reg >= len_reg);
   end

   assign bus.PT_DATA        = pt_data;
   assign bus.PT_STROBE      = strobe;
   assign bus.PT_STOP        = stop;
   assign bus.PHOTO_TAPE_REV = rev;
   assign bus.BUSY           = busy;
   assign bus.PT_EOT         = eot;

endmodule

// File: doc/photo_tape_reader.md
Name: photo_tape_reader

Overview:
- Peripheral-side model of the G-15 photoelectric tape reader. It responds to the tape-motion commands issued by the I/O control logic (OC register decode) and delivers 5-bit tape frames to the input path at a paced character rate.
- Supports reverse search to the preceding stop code and reports reverse motion back to the I/O control through PHOTO_TAPE_REV.
- Tape image is loaded by the host into internal storage before or between reads.

Parameters:
- DEPTH, 4096, tape image capacity in frames (power of 2).
- CHAR_CYCLES, 1000, CLOCK cycles between forward frames.
- REV_CYCLES, 250, CLOCK cycles per reverse step.
- START_CYCLES, 2000, CLOCK cycles from forward start to the first frame.

Ports:
- CLOCK  in  1  system clock
- rst  in  1  reset; synchronous, active-high, sampled on CLOCK rising edge
- PHOTO_TAPE_FWD  in  1  level; run tape forward while high
- TAPE_REV_CMD  in  1  pulse; start reverse search
- HOST_WE  in  1  host frame write strobe
- HOST_ADDR  in  $clog2(DEPTH)  host write address
- HOST_DATA  in  5  host frame
- HOST_LEN_WE  in  1  load tape length
- HOST_LEN  in  $clog2(DEPTH)+1  tape length in frames
- PT_DATA  out  5  current frame, valid with PT_STROBE
- PT_STROBE  out  1  one-cycle frame-valid pulse
- PT_STOP  out  1  one-cycle pulse coincident with a strobe carrying STOP_CODE
- PHOTO_TAPE_REV  out  1  high while reversing
- PT_EOT  out  1  level; position >= length
- BUSY  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, pos=0, len=0, timer=0. All outputs 0 except PT_EOT=1 (0>=0). Reset mid-operation aborts immediately; RAM contents are retained.
- Host writes: honoured only when BUSY=0 and ignored otherwise. HOST_LEN_WE also clears pos to 0. HOST_LEN is clamped to DEPTH.
- Storage: tape_ram, synchronous read, 1-cycle latency, single read port addressed by the FSM.
- States:
  - IDLE:
    - TAPE_REV_CMD with pos>0 -> REV_STEP. TAPE_REV_CMD is ignored when pos=0.
    - Else PHOTO_TAPE_FWD with pos<len -> START, timer=START_CYCLES-1.
    - REV takes priority when both are asserted.
  - START: counts down. PHOTO_TAPE_FWD low -> IDLE. At timer=0, issue read at pos -> FWD_READ.
  - FWD_READ (1 cycle): PT_DATA<=rdata, PT_STROBE=1, PT_STOP=(rdata==STOP_CODE), pos<=pos+1 -> FWD_WAIT, timer=CHAR_CYCLES-2.
  - FWD_WAIT: counts down.
    - PHOTO_TAPE_FWD low -> IDLE, pos unchanged.
    - timer=0 and pos<len -> issue read -> FWD_READ.
    - timer=0 and pos>=len -> FWD_EOT.
    - Frame spacing is exactly CHAR_CYCLES between strobes.
  - FWD_EOT: no strobes. Exits to IDLE when PHOTO_TAPE_FWD drops.
  - REV_STEP: PHOTO_TAPE_REV=1, pos<=pos-1, issue read at pos-2 (when pos>=2) -> REV_WAIT, timer=REV_CYCLES-1.
  - REV_WAIT: PHOTO_TAPE_REV=1. At timer=0:
    - pos=0 or rdata==STOP_CODE -> IDLE (pos rests just after the previous stop code).
    - Else -> REV_STEP.
    - PHOTO_TAPE_FWD is ignored during reverse.
- Reverse semantics: the frame just before the starting position is always stepped over, so a reverse from just after a stop code backs up one full block.
- PT_DATA holds its last value between strobes.
- PT_STROBE never asserts outside FWD_READ.
- PT_EOT is combinational from registered pos and len.
- Width rule: pos is $clog2(DEPTH)+1 bits and never wraps. It saturates at len going forward and at 0 in reverse.

Decomposition:
- Package g15_tape_pkg:
  - STOP_CODE = 5'b10000
  - frame_t (logic [4:0])
  - reader state enum ptr_state_t
- Sub-module tape_ram (DEPTH x 5):
  - one write port (host)
  - one synchronous read port (FSM)

Test Plan:
- Load len=3 frames {01,10,02}, CHAR_CYCLES=8, START_CYCLES=4, raise FWD -> strobes at cycles 5,13,21 after FWD; data 01,10,02; PT_STOP only on 2nd; PT_EOT=1 after 3rd; no further strobes.
- FWD high, dropped 3 cycles after first strobe then re-raised -> pos=1 retained; next strobe delivers frame[1]=10 after START_CYCLES.
- Tape {01,10,03,04,10,05}, read to pos=5, pulse TAPE_REV_CMD, REV_CYCLES=4 -> PHOTO_TAPE_REV high through steps to pos=2; ends IDLE with pos=2; next forward frame 03.
- Reverse from pos=2 on tape {01,02} (no stop code) -> stops at pos=0; PHOTO_TAPE_REV drops; BUSY=0.
- HOST_WE to addr 0 while BUSY=1 -> RAM unchanged; same write when idle -> read back on next pass.
- Assert rst during REV_WAIT -> next cycle PHOTO_TAPE_REV=0, BUSY=0, pos=0, len=0, PT_EOT=1; RAM data preserved after new HOST_LEN load.
